// File: rtl/alu_seg_pipe.sv
// Two-stage WIDTH-bit ALU with Z/N/C/V flags, plus an 8-digit multiplexed
// hex display scanner showing the latest result snapshot.
module alu_seg_pipe #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic             CLK100MHZ,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       option,
   input  logic             load,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic [6:0]       segment,
   output logic             DP,
   output logic [7:0]       an,
   output logic [7:0]       light
);

   localparam int unsigned NDIG = (WIDTH + 3) / 4;
   localparam int unsigned SHW  = $clog2(WIDTH);
   localparam int unsigned CW   = $clog2(SCAN_DIV);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
      OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_SLT = 3'd7
   } op_e;

   // ---------------- stage 1: operand capture ----------------
   logic [WIDTH-1:0] a_q, b_q;
   op_e              op_q;
   logic             valid1_q;

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         valid1_q <= 1'b0;
      end else begin
         valid1_q <= load;
         if (load) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op_e'(option);
         end
      end
   end

   // ---------------- stage 2: ALU ----------------
   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   sum_w, dif_w, shl_w, shr_w;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;

   assign amt   = SHW'(32'(b_q) % WIDTH);
   assign sum_w = {1'b0, a_q} + {1'b0, b_q};
   assign dif_w = {1'b0, a_q} - {1'b0, b_q};
   // Extra bit on the far side of each shift catches the last bit shifted out.
   assign shl_w = {1'b0, a_q} << amt;
   assign shr_w = {a_q, 1'b0} >> amt;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = dif_w[WIDTH-1:0];
            alu_c   = ~dif_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_SHL: begin
            alu_res = shl_w[WIDTH-1:0];
            alu_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_w[WIDTH:1];
            alu_c   = shr_w[0];
         end
         OP_SLT: alu_res = WIDTH'($signed(a_q) < $signed(b_q));
         default: alu_res = '0;
      endcase
   end

   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic [2:0]       opl_q;
   logic             rv_q, done_q, done_d;

   // Done sets with a new result; a load without a coincident result clears it.
   always_comb begin
      done_d = done_q;
      if (valid1_q)  done_d = 1'b1;
      else if (load) done_d = 1'b0;
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         flags_q  <= '0;
         opl_q    <= '0;
         rv_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rv_q   <= valid1_q;
         done_q <= done_d;
         if (valid1_q) begin
            result_q <= alu_res;
            flags_q  <= {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
            opl_q    <= op_q;
         end
      end
   end

   assign result       = result_q;
   assign result_valid = rv_q;
   assign light        = {done_q, opl_q, flags_q};

   // ---------------- display scanner ----------------
   logic [CW-1:0]    pre_q, pre_d;
   logic [2:0]       dig_q, dig_d;
   logic [WIDTH-1:0] snap_res_q, snap_res_d;
   logic             snap_cv_q, snap_cv_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             pre_wrap, dig_active;
   logic [31:0]      snap_ext;
   logic [3:0]       nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
      endcase
   endfunction

   // Outputs decode from next-state so an/segment/DP move with the digit index.
   always_comb begin
      pre_wrap   = (pre_q == CW'(SCAN_DIV - 1));
      pre_d      = pre_wrap ? '0 : pre_q + CW'(1);
      dig_d      = pre_wrap ? dig_q + 3'd1 : dig_q;
      snap_res_d = snap_res_q;
      snap_cv_d  = snap_cv_q;
      if (pre_wrap && (dig_q == 3'd7)) begin
         snap_res_d = result_q;
         snap_cv_d  = flags_q[1] | flags_q[0];
      end
      snap_ext   = 32'(snap_res_d);
      nib        = 4'(snap_ext >> {dig_d, 2'b00});
      dig_active = (32'(dig_d) < NDIG);
      an_d       = dig_active ? ~(8'd1 << dig_d) : 8'hFF;
      seg_d      = dig_active ? hex7(nib) : 7'h7F;
      dp_d       = ~((dig_d == 3'd0) && snap_cv_d);
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         pre_q      <= '0;
         dig_q      <= '0;
         snap_res_q <= '0;
         snap_cv_q  <= 1'b0;
         an_q       <= 8'hFE;
         seg_q      <= 7'b1000000;
         dp_q       <= 1'b1;
      end else begin
         pre_q      <= pre_d;
         dig_q      <= dig_d;
         snap_res_q <= snap_res_d;
         snap_cv_q  <= snap_cv_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an      = an_q;
   assign segment = seg_q;
   assign DP      = dp_q;

endmodule

// File: tb/tb_alu_seg_pipe.sv
// Scoreboard bench for alu_seg_pipe: arithmetic reference model plus a
// cycle-count display model, with a monitor decoupled from the driver.
module tb_alu_seg_pipe;

   localparam int W    = 8;
   localparam int SD   = 4;
   localparam int NDIG = 2;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] flags;
      logic [7:0] res;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] A = '0, B = '0;
   logic [2:0] option = '0;
   logic       load = 1'b0;
   logic [7:0] result;
   logic       result_valid;
   logic [6:0] segment;
   logic       DP;
   logic [7:0] an;
   logic [7:0] light;

   alu_seg_pipe #(.WIDTH(W), .SCAN_DIV(SD)) dut (
      .CLK100MHZ(clk), .rst(rst), .A(A), .B(B), .option(option), .load(load),
      .result(result), .result_valid(result_valid), .segment(segment),
      .DP(DP), .an(an), .light(light)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   logic [7:0] exp_res   = '0;
   logic [3:0] exp_flags = '0;
   logic [2:0] exp_op    = '0;

   logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference ALU in plain integer arithmetic.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      exp_t e;
      int ua, ub, sa, sb, r, c, v, amt;
      ua = int'(a); ub = int'(b);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      amt = ub % W;
      r = 0; c = 0; v = 0;
      case (op)
         3'd0: begin r = ua + ub; c = (r > 255) ? 1 : 0;
                     v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0; end
         3'd1: begin r = ua - ub; c = (ua >= ub) ? 1 : 0;
                     v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0; end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: begin r = ua << amt; c = (amt != 0) ? (ua >> (W - amt)) & 1 : 0; end
         3'd6: begin r = ua >> amt; c = (amt != 0) ? (ua >> (amt - 1)) & 1 : 0; end
         default: r = (sa < sb) ? 1 : 0;
      endcase
      e.res   = 8'(r & 255);
      e.op    = op;
      e.flags = {e.res == 8'h00, e.res[7], c[0], v[0]};
      return e;
   endfunction

   // Timing model: load history, done bit, edges since reset and frame snapshot.
   logic       ld0, ld1, exp_done;
   int         n;
   logic [7:0] snap_res;
   logic       snap_cv;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ld0 <= 1'b0; ld1 <= 1'b0; exp_done <= 1'b0;
         n <= 0; snap_res <= '0; snap_cv <= 1'b0;
      end else begin
         ld0      <= load;
         ld1      <= ld0;
         exp_done <= ld0 ? 1'b1 : (load ? 1'b0 : exp_done);
         n        <= n + 1;
         if ((n + 1) % (8 * SD) == 0) begin
            snap_res <= exp_res;
            snap_cv  <= exp_flags[1] | exp_flags[0];
         end
      end
   end

   // Monitor: compares every cycle, pops the scoreboard on result_valid.
   always begin
      int dig, nib;
      exp_t e;
      logic [7:0] x_an;
      logic [6:0] x_seg;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_res = '0; exp_flags = '0; exp_op = '0;
      end
      check("result_valid", 32'(result_valid), 32'(ld1));
      if (result_valid) begin
         check("sb_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            exp_res = e.res; exp_flags = e.flags; exp_op = e.op;
         end
      end
      check("result", 32'(result), 32'(exp_res));
      check("light", 32'(light), 32'({exp_done, exp_op, exp_flags}));
      dig   = (n / SD) % 8;
      nib   = (int'(snap_res) >> (4 * dig)) & 15;
      x_an  = (dig < NDIG) ? ~(8'd1 << dig) : 8'hFF;
      x_seg = (dig < NDIG) ? hex_tab[nib] : 7'h7F;
      check("an", 32'(an), 32'(x_an));
      check("segment", 32'(segment), 32'(x_seg));
      check("DP", 32'(DP), 32'(!(dig == 0 && snap_cv)));
   end

   task automatic step(input logic ld, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      @(negedge clk);
      A = a; B = b; option = op; load = ld;
      if (ld) exp_q.push_back(model(a, b, op));
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 8'h00, 3'd0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      load = 1'b0;
      rst  = 1'b1;
      exp_q.delete();
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);
      // Reset while an ADD is in flight: it must never emerge.
      step(1'b1, 8'h11, 8'h22, 3'd0);
      do_reset(2);
      idle(3);
      // Directed vectors.
      step(1'b1, 8'hF0, 8'h20, 3'd0);
      idle(2);
      step(1'b1, 8'h80, 8'h01, 3'd1);
      step(1'b1, 8'h01, 8'h02, 3'd1);
      step(1'b1, 8'h81, 8'h09, 3'd5);
      step(1'b1, 8'hFF, 8'h01, 3'd7);
      step(1'b1, 8'h81, 8'h08, 3'd6);
      step(1'b1, 8'h81, 8'h0B, 3'd6);
      idle(3);
      step(1'b1, 8'hCC, 8'hAA, 3'd2);
      step(1'b1, 8'hCC, 8'hAA, 3'd3);
      step(1'b1, 8'hCC, 8'hAA, 3'd4);
      idle(4);
      // Display: 0x3A, then a mid-frame change that must wait for frame end.
      step(1'b1, 8'h3A, 8'h00, 3'd3);
      idle(70);
      step(1'b1, 8'h7F, 8'h01, 3'd0);
      idle(45);
      step(1'b1, 8'h5C, 8'h00, 3'd3);
      idle(70);
      // Random traffic with one asynchronous reset part-way through.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset(2);
         step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      end
      idle(5);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
